// File: rtl/ni_pkg.sv
// Shared flit-ID constants, packetizer state encoding and flit-width helper.
package ni_pkg;

   localparam logic [1:0] FLIT_HEAD = 2'b10;
   localparam logic [1:0] FLIT_BODY = 2'b00;
   localparam logic [1:0] FLIT_TAIL = 2'b11;

   // State names the flit to be loaded into the output stage next; ST_DROP sinks self-addressed payload.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BODY = 2'd1,
      ST_TAIL = 2'd2,
      ST_DROP = 2'd3
   } ni_state_e;

   function automatic int unsigned flit_width(input int unsigned id_w, input int unsigned data_w);
      return id_w + data_w;
   endfunction

endpackage

// File: rtl/ni_flit_reg.sv
// Registered valid/ready output stage holding the outgoing flit.
module ni_flit_reg #(
   parameter int unsigned FLIT_W = 10
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              in_valid_i,
   input  logic [FLIT_W-1:0] in_flit_i,
   output logic              in_ready_o,
   output logic [FLIT_W-1:0] flit_o,
   output logic              flit_valid_o,
   input  logic              flit_ready_i
);

   logic [FLIT_W-1:0] flit_q;
   logic              valid_q;

   assign in_ready_o   = !valid_q || flit_ready_i;
   assign flit_o       = flit_q;
   assign flit_valid_o = valid_q;

   // Data only updates on a real load so it stays put while the valid bit drains.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         flit_q  <= '0;
         valid_q <= 1'b0;
      end else if (in_ready_o) begin
         valid_q <= in_valid_i;
         if (in_valid_i) begin
            flit_q <= in_flit_i;
         end
      end
   end

endmodule

// File: rtl/ni_packetizer.sv
// NI transmitter: send request + payload words -> HEAD/BODY/TAIL flits.
// Optional NI_SELF_DROP_EN: self-addressed packets are sunk and flagged on err_self_o.
module ni_packetizer
   import ni_pkg::*;
#(
   parameter int unsigned COL_ADDR_W = 4,
   parameter int unsigned ROW_ADDR_W = 4,
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned FLIT_ID_W  = 2,
   parameter int unsigned PKT_LEN_W  = 4,
   parameter logic [3:0]  COL_CORD   = 4'd0,
   parameter logic [3:0]  ROW_CORD   = 4'd0
) (
   input  logic                                   clk_i,
   input  logic                                   rst_i,
   input  logic                                   pkt_valid_i,
   output logic                                   pkt_ready_o,
   input  logic [COL_ADDR_W-1:0]                  pkt_col_addr_i,
   input  logic [ROW_ADDR_W-1:0]                  pkt_row_addr_i,
   input  logic [PKT_LEN_W-1:0]                   pkt_len_i,
   input  logic                                   data_valid_i,
   input  logic [DATA_W-1:0]                      data_i,
   output logic                                   data_ready_o,
   output logic [flit_width(FLIT_ID_W,DATA_W)-1:0] flit_o,
   output logic                                   flit_valid_o,
   input  logic                                   flit_ready_i,
   output logic                                   busy_o,
   output logic                                   err_self_o
);

   localparam int unsigned FLIT_W = flit_width(FLIT_ID_W, DATA_W);

   if (DATA_W < COL_ADDR_W + ROW_ADDR_W) begin : g_bad_data_w
      $error("ni_packetizer: DATA_W cannot hold the head address");
   end
   if (((COL_CORD >> COL_ADDR_W) != 4'd0) || ((ROW_CORD >> ROW_ADDR_W) != 4'd0)) begin : g_bad_cord
      $error("ni_packetizer: node coordinate exceeds address width");
   end

   ni_state_e            state_q, state_d;
   logic [PKT_LEN_W-1:0] cnt_q, cnt_d;
   logic                 adv;
   logic                 accept;
   logic                 consume;
   logic                 self_dst;
   logic                 out_valid;
   logic [FLIT_W-1:0]    out_flit;

`ifdef NI_SELF_DROP_EN
   assign self_dst = (pkt_col_addr_i == COL_ADDR_W'(COL_CORD)) &&
                     (pkt_row_addr_i == ROW_ADDR_W'(ROW_CORD));
`else
   assign self_dst = 1'b0;
`endif

   assign accept  = pkt_valid_i && pkt_ready_o;
   assign consume = data_valid_i && data_ready_o;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state: the state moves to IDLE once the TAIL is loaded, so a new head can follow it directly.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               cnt_d = pkt_len_i;
               if (self_dst) begin
                  state_d = (pkt_len_i == '0) ? ST_IDLE : ST_DROP;
               end else begin
                  state_d = (pkt_len_i > PKT_LEN_W'(1)) ? ST_BODY : ST_TAIL;
               end
            end
         end
         ST_BODY: begin
            if (consume) begin
               cnt_d = cnt_q - PKT_LEN_W'(1);
               if (cnt_q == PKT_LEN_W'(2)) begin
                  state_d = ST_TAIL;
               end
            end
         end
         ST_TAIL: begin
            if (adv && out_valid) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end
         end
         ST_DROP: begin
            if (consume) begin
               cnt_d = cnt_q - PKT_LEN_W'(1);
               if (cnt_q == PKT_LEN_W'(1)) begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs and output-stage load; handshakes are held off while reset is asserted.
   always_comb begin
      pkt_ready_o  = 1'b0;
      data_ready_o = 1'b0;
      out_valid    = 1'b0;
      out_flit     = '0;
      if (!rst_i) begin
         case (state_q)
            ST_IDLE: begin
               pkt_ready_o = adv;
               out_valid   = pkt_valid_i && !self_dst;
               out_flit    = {FLIT_ID_W'(FLIT_HEAD), DATA_W'({pkt_row_addr_i, pkt_col_addr_i})};
            end
            ST_BODY: begin
               data_ready_o = adv;
               out_valid    = data_valid_i;
               out_flit     = {FLIT_ID_W'(FLIT_BODY), data_i};
            end
            ST_TAIL: begin
               data_ready_o = adv && (cnt_q != '0);
               out_valid    = data_valid_i || (cnt_q == '0);
               out_flit     = {FLIT_ID_W'(FLIT_TAIL), (cnt_q == '0) ? DATA_W'(0) : data_i};
            end
            ST_DROP: begin
               data_ready_o = adv;
            end
            default: ;
         endcase
      end
   end

   ni_flit_reg #(
      .FLIT_W (FLIT_W)
   ) u_flit_reg (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .in_valid_i   (out_valid),
      .in_flit_i    (out_flit),
      .in_ready_o   (adv),
      .flit_o       (flit_o),
      .flit_valid_o (flit_valid_o),
      .flit_ready_i (flit_ready_i)
   );

   // Busy stays up while the TAIL still sits in the output stage.
   assign busy_o = (state_q != ST_IDLE) ||
                   (flit_valid_o && (flit_o[FLIT_W-1 -: FLIT_ID_W] == FLIT_ID_W'(FLIT_TAIL)));

`ifdef NI_SELF_DROP_EN
   logic err_self_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         err_self_q <= 1'b0;
      end else begin
         err_self_q <= accept && self_dst;
      end
   end

   assign err_self_o = err_self_q;
`else
   assign err_self_o = 1'b0;
`endif

endmodule

// File: tb/tb_ni_packetizer.sv
// Directed per-cycle vector bench for ni_packetizer, plus hand sequences for stalls and self-addressing.
module tb_ni_packetizer;

   typedef struct {
      logic       rst;
      logic       pv;
      logic [3:0] col;
      logic [3:0] row;
      logic [3:0] len;
      logic       dv;
      logic [7:0] d;
      logic       fr;
      logic       e_pr;
      logic       e_dr;
      logic       e_fv;
      logic [9:0] e_f;
      logic       e_busy;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       pkt_valid;
   logic [3:0] col;
   logic [3:0] row;
   logic [3:0] len;
   logic       data_valid;
   logic [7:0] data;
   logic       flit_ready;
   logic       pkt_ready;
   logic       data_ready;
   logic [9:0] flit;
   logic       flit_valid;
   logic       busy;
   logic       err_self;

   int n_pass = 0;
   int n_chk  = 0;

   always #5 clk = ~clk;

   ni_packetizer dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .pkt_valid_i    (pkt_valid),
      .pkt_ready_o    (pkt_ready),
      .pkt_col_addr_i (col),
      .pkt_row_addr_i (row),
      .pkt_len_i      (len),
      .data_valid_i   (data_valid),
      .data_i         (data),
      .data_ready_o   (data_ready),
      .flit_o         (flit),
      .flit_valid_o   (flit_valid),
      .flit_ready_i   (flit_ready),
      .busy_o         (busy),
      .err_self_o     (err_self)
   );

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   function automatic vec_t mk(input logic r, input logic pv, input logic [3:0] c, input logic [3:0] rw,
                               input logic [3:0] l, input logic dv, input logic [7:0] d, input logic fr,
                               input logic pr, input logic dr, input logic fv, input logic [9:0] f,
                               input logic b);
      vec_t v;
      v.rst = r; v.pv = pv; v.col = c; v.row = rw; v.len = l; v.dv = dv; v.d = d; v.fr = fr;
      v.e_pr = pr; v.e_dr = dr; v.e_fv = fv; v.e_f = f; v.e_busy = b;
      return v;
   endfunction

   task automatic drive(input logic pv, input logic [3:0] c, input logic [3:0] rw, input logic [3:0] l,
                        input logic dv, input logic [7:0] d);
      @(negedge clk);
      pkt_valid = pv; col = c; row = rw; len = l; data_valid = dv; data = d;
      #1;
   endtask

   initial begin
      vec_t vecs[$];
      int   words;

      rst = 1'b1; pkt_valid = 1'b0; col = '0; row = '0; len = '0;
      data_valid = 1'b0; data = '0; flit_ready = 1'b1;

      // rst pv col row len dv data fr | pr dr fv flit busy
      vecs.push_back(mk(1,0,0,0,0,0,8'h00,1, 0,0,0,10'h000,0));
      // dest (2,1), N=3
      vecs.push_back(mk(0,1,2,1,3,0,8'h00,1, 1,0,0,10'h000,0));
      vecs.push_back(mk(0,0,0,0,0,1,8'hA1,1, 0,1,1,10'h212,1));
      vecs.push_back(mk(0,0,0,0,0,1,8'hA2,1, 0,1,1,10'h0A1,1));
      vecs.push_back(mk(0,0,0,0,0,1,8'hA3,1, 0,1,1,10'h0A2,1));
      vecs.push_back(mk(0,0,0,0,0,0,8'h00,1, 1,0,1,10'h3A3,1));
      vecs.push_back(mk(0,0,0,0,0,0,8'h00,1, 1,0,0,10'h000,0));
      // dest (1,0), N=0: payload offered but never consumed
      vecs.push_back(mk(0,1,1,0,0,0,8'h00,1, 1,0,0,10'h000,0));
      vecs.push_back(mk(0,0,0,0,0,1,8'h55,1, 0,0,1,10'h201,1));
      vecs.push_back(mk(0,0,0,0,0,1,8'h55,1, 1,0,1,10'h300,1));
      vecs.push_back(mk(0,0,0,0,0,0,8'h00,1, 1,0,0,10'h000,0));
      // dest (3,2), N=2, HEAD back-pressured for 3 cycles
      vecs.push_back(mk(0,1,3,2,2,0,8'h00,1, 1,0,0,10'h000,0));
      vecs.push_back(mk(0,0,0,0,0,1,8'hB1,0, 0,0,1,10'h223,1));
      vecs.push_back(mk(0,0,0,0,0,1,8'hB1,0, 0,0,1,10'h223,1));
      vecs.push_back(mk(0,0,0,0,0,1,8'hB1,0, 0,0,1,10'h223,1));
      vecs.push_back(mk(0,0,0,0,0,1,8'hB1,1, 0,1,1,10'h223,1));
      vecs.push_back(mk(0,0,0,0,0,1,8'hB2,1, 0,1,1,10'h0B1,1));
      vecs.push_back(mk(0,0,0,0,0,0,8'h00,1, 1,0,1,10'h3B2,1));
      vecs.push_back(mk(0,0,0,0,0,0,8'h00,1, 1,0,0,10'h000,0));
      // two back-to-back N=1 packets to (1,1)
      vecs.push_back(mk(0,1,1,1,1,0,8'h00,1, 1,0,0,10'h000,0));
      vecs.push_back(mk(0,0,0,0,0,1,8'hC1,1, 0,1,1,10'h211,1));
      vecs.push_back(mk(0,1,1,1,1,0,8'h00,1, 1,0,1,10'h3C1,1));
      vecs.push_back(mk(0,0,0,0,0,1,8'hC2,1, 0,1,1,10'h211,1));
      vecs.push_back(mk(0,0,0,0,0,0,8'h00,1, 1,0,1,10'h3C2,1));
      vecs.push_back(mk(0,0,0,0,0,0,8'h00,1, 1,0,0,10'h000,0));
      // dest (2,3), N=4, reset while the first BODY is on the output
      vecs.push_back(mk(0,1,2,3,4,0,8'h00,1, 1,0,0,10'h000,0));
      vecs.push_back(mk(0,0,0,0,0,1,8'hD1,1, 0,1,1,10'h232,1));
      vecs.push_back(mk(1,0,0,0,0,1,8'hD2,1, 0,0,1,10'h0D1,1));
      vecs.push_back(mk(0,0,0,0,0,0,8'h00,1, 1,0,0,10'h000,0));
      vecs.push_back(mk(0,1,2,3,1,0,8'h00,1, 1,0,0,10'h000,0));
      vecs.push_back(mk(0,0,0,0,0,1,8'hE1,1, 0,1,1,10'h232,1));
      vecs.push_back(mk(0,0,0,0,0,0,8'h00,1, 1,0,1,10'h3E1,1));
      vecs.push_back(mk(0,0,0,0,0,0,8'h00,1, 1,0,0,10'h000,0));

      @(negedge clk);
      #1;
      check("reset flit_o", 16'(flit), 16'h0000);
      check("reset err_self_o", 16'(err_self), 16'h0000);

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         rst = vecs[i].rst; pkt_valid = vecs[i].pv; col = vecs[i].col; row = vecs[i].row;
         len = vecs[i].len; data_valid = vecs[i].dv; data = vecs[i].d; flit_ready = vecs[i].fr;
         #1;
         check($sformatf("v%0d pkt_ready_o", i), 16'(pkt_ready), 16'(vecs[i].e_pr));
         check($sformatf("v%0d data_ready_o", i), 16'(data_ready), 16'(vecs[i].e_dr));
         check($sformatf("v%0d flit_valid_o", i), 16'(flit_valid), 16'(vecs[i].e_fv));
         check($sformatf("v%0d busy_o", i), 16'(busy), 16'(vecs[i].e_busy));
         check($sformatf("v%0d err_self_o", i), 16'(err_self), 16'h0000);
         if (vecs[i].e_fv) check($sformatf("v%0d flit_o", i), 16'(flit), 16'(vecs[i].e_f));
      end

      // Payload stall: dest (0,1), N=2, gaps between words drain the output with no bubble flit
      rst = 1'b0; flit_ready = 1'b1;
      drive(1, 0, 1, 2, 0, 8'h00);
      check("stall accept", 16'(pkt_ready), 16'h0001);
      drive(0, 0, 0, 0, 0, 8'h00);
      check("stall head valid", 16'(flit_valid), 16'h0001);
      check("stall head flit", 16'(flit), 16'h0210);
      check("stall head data_ready", 16'(data_ready), 16'h0001);
      drive(0, 0, 0, 0, 0, 8'h00);
      check("stall no bubble", 16'(flit_valid), 16'h0000);
      check("stall busy", 16'(busy), 16'h0001);
      drive(0, 0, 0, 0, 1, 8'hF1);
      check("stall gap valid", 16'(flit_valid), 16'h0000);
      drive(0, 0, 0, 0, 0, 8'h00);
      check("stall body valid", 16'(flit_valid), 16'h0001);
      check("stall body flit", 16'(flit), 16'h00F1);
      drive(0, 0, 0, 0, 1, 8'hF2);
      check("stall gap2 valid", 16'(flit_valid), 16'h0000);
      check("stall gap2 data_ready", 16'(data_ready), 16'h0001);
      drive(0, 0, 0, 0, 0, 8'h00);
      check("stall tail flit", 16'(flit), 16'h03F2);
      check("stall tail busy", 16'(busy), 16'h0001);
      drive(0, 0, 0, 0, 0, 8'h00);
      check("stall done valid", 16'(flit_valid), 16'h0000);
      check("stall done busy", 16'(busy), 16'h0000);

      // Self-addressed packet to (0,0), N=2
      words = 0;
`ifdef NI_SELF_DROP_EN
      drive(1, 0, 0, 2, 0, 8'h00);
      check("self accept", 16'(pkt_ready), 16'h0001);
      drive(0, 0, 0, 0, 1, 8'h11);
      if (data_valid && data_ready) words++;
      check("self err pulse", 16'(err_self), 16'h0001);
      check("self no flit 1", 16'(flit_valid), 16'h0000);
      check("self busy", 16'(busy), 16'h0001);
      drive(0, 0, 0, 0, 1, 8'h22);
      if (data_valid && data_ready) words++;
      check("self err cleared", 16'(err_self), 16'h0000);
      check("self no flit 2", 16'(flit_valid), 16'h0000);
      drive(0, 0, 0, 0, 1, 8'h33);
      if (data_valid && data_ready) words++;
      check("self no flit 3", 16'(flit_valid), 16'h0000);
      check("self idle busy", 16'(busy), 16'h0000);
      check("self words consumed", 16'(words), 16'h0002);
`else
      drive(1, 0, 0, 2, 0, 8'h00);
      check("self accept", 16'(pkt_ready), 16'h0001);
      drive(0, 0, 0, 0, 1, 8'h11);
      if (data_valid && data_ready) words++;
      check("self head flit", 16'(flit), 16'h0200);
      check("self head valid", 16'(flit_valid), 16'h0001);
      check("self err tied", 16'(err_self), 16'h0000);
      drive(0, 0, 0, 0, 1, 8'h22);
      if (data_valid && data_ready) words++;
      check("self body flit", 16'(flit), 16'h0011);
      drive(0, 0, 0, 0, 0, 8'h00);
      check("self tail flit", 16'(flit), 16'h0322);
      check("self words consumed", 16'(words), 16'h0002);
`endif
      drive(0, 0, 0, 0, 0, 8'h00);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/ni_packetizer.md
# ni_packetizer

Network-interface transmitter that turns a processing element's send request (destination column/row plus a stream of payload words) into a HEAD/BODY/TAIL flit sequence, injected into the local router's resource input port. The head flit carries the destination coordinates that the downstream dimension-ordered router decodes at every hop. It is the source end of the routing-header protocol, with one registered flit output and valid/ready handshakes on all sides.

## Interface
- COL_CORD, 4'd0, column of this node
- ROW_CORD, 4'd0, row of this node
- COL_ADDR_W, 4, column address width
- ROW_ADDR_W, 4, row address width
- DATA_W, 8, payload width; must be >= COL_ADDR_W+ROW_ADDR_W
- FLIT_ID_W, 2, flit type field width
- PKT_LEN_W, 4, payload-length field width

Ports:
- clk_i  in  1  clock; single clock domain
- rst_i  in  1  reset; synchronous, active-high
- pkt_valid_i  in  1  send request valid
- pkt_ready_o  out  1  request accepted when valid&&ready
- pkt_col_addr_i  in  COL_ADDR_W  destination column
- pkt_row_addr_i  in  ROW_ADDR_W  destination row
- pkt_len_i  in  PKT_LEN_W  payload word count N
- data_valid_i  in  1  payload word valid
- data_i  in  DATA_W  payload word
- data_ready_o  out  1  payload word consumed when valid&&ready
- flit_o  out  FLIT_ID_W+DATA_W  {id, data}
- flit_valid_o  out  1  flit valid
- flit_ready_i  in  1  router buffer can accept
- busy_o  out  1  packet in progress
- err_self_o  out  1  self-addressed drop pulse (see Configuration)

## Operation
- Flit IDs: HEAD=2'b10, BODY=2'b00, TAIL=2'b11.
- HEAD data = zero-extended {row_addr, col_addr}; col in LSBs.
- N>=1: HEAD, N-1 BODY flits, TAIL carrying the last word. N=0: HEAD then TAIL with data 0; no payload consumed.
- FSM: IDLE -> HEAD (on request) -> BODY (remaining>1) or TAIL (remaining==1, or N==0) -> IDLE after TAIL handshake.
- Remaining-word counter loaded with N on accept; decremented per consumed word; PKT_LEN_W wide, no wrap possible.
- Output register advance: adv = !flit_valid_o || flit_ready_i.
- pkt_ready_o = (state==IDLE) && adv.
- data_ready_o = (state in BODY/TAIL with N>0) && adv.
- busy_o high from request accept until the TAIL handshake.
- Payload stall (data_valid_i low): flit_valid_o drops after current flit drains; no bubble flit is emitted.
- Destination addresses are latched on accept; later changes on pkt_* are ignored.

## Timing
- Reset: flit_o=0, flit_valid_o=0, pkt_ready_o=0 during reset then 1, data_ready_o=0, busy_o=0, err_self_o=0, state IDLE, counter 0.
- Request accepted at cycle T -> HEAD valid at T+1.
- Body words: word consumed at cycle T appears on flit_o at T+1.
- Throughput 1 flit/cycle with flit_ready_i held high; N-word packet occupies N+1 cycles back-to-back.
- flit_o stable while flit_valid_o && !flit_ready_i.
- Back-to-back packets: TAIL handshake and next request accept may occur in the same cycle.
- Reset mid-packet: in-flight packet discarded, no TAIL emitted; the next flit out is a new HEAD.

## Configuration
- NI_SELF_DROP_EN defined: a request with destination == (COL_CORD,ROW_CORD) is accepted, its N words consumed at 1/cycle, no flits emitted; err_self_o pulses 1 cycle on accept.
- Undefined: self-addressed packets are sent normally; err_self_o tied 0.

## Structure
- Shared package ni_pkg: flit ID constants, state encoding, flit-width function.
- One sub-module: ni_flit_reg, a registered valid/ready output stage holding flit_o/flit_valid_o.

## Test plan
- Dest (2,1), N=3, words 0xA1,0xA2,0xA3, ready high -> flits {10,0x12},{00,0xA1},{00,0xA2},{11,0xA3} on consecutive cycles T+1..T+4.
- N=0 to (1,0) -> {10,0x01},{11,0x00}; data_ready_o never asserted.
- N=2, flit_ready_i low for 3 cycles on HEAD -> HEAD held stable; no word consumed until the HEAD handshake.
- Two back-to-back N=1 packets -> HEAD,TAIL,HEAD,TAIL with no idle cycle.
- rst_i after the first BODY of an N=4 packet -> outputs return to reset values next cycle; the following request starts with a HEAD.
- With NI_SELF_DROP_EN, dest=(COL_CORD,ROW_CORD), N=2 -> no flit_valid_o; err_self_o 1 cycle; 2 words consumed.
